// File: rtl/scan_ctrl_pkg.sv
// Shared types and helpers for the scan chain sequencer.
//   state_e   : sequencer phases (IDLE, LOAD, CAPTURE, UNLOAD, REPORT)
//   cnt_width : bits needed to hold values 0..n (never less than 1)
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    REPORT  = 3'd4
  } state_e;

  // Counter width for a count range of 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/scan_piso_sipo.sv
// Single shift register used both to serialise the load pattern (MSB first)
// and to deserialise the unloaded response back in through its LSB.
//   clk, rst   : clock, synchronous active-high reset
//   load       : parallel load of par_in (has priority over shift)
//   shift      : shift left by one, ser_in enters at bit 0
//   ser_in     : serial input bit
//   par_in     : parallel load value
//   par_next_c : next-state register contents (combinational)
module scan_piso_sipo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] par_next_c
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Next value: load, shift left with serial fill, or hold.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = par_in;
    end else if (shift) begin
      sr_d = WIDTH'({sr_q, ser_in});
    end
  end

  // The owner needs the post-edge value to register SI and the response.
  assign par_next_c = sr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: shifts a pattern into one chain, runs capture cycles,
// shifts the response out and compares it against masked expected data.
//   CLK, RST  : clock shared with the chain, synchronous active-high reset
//   START     : one-cycle request, honoured only in IDLE
//   PAT_IN    : pattern, bit i lands in chain element i (element 0 nearest SI)
//   EXP_IN    : expected response
//   MASK_IN   : compare enable per bit (1 = compare)
//   SO        : chain tail output (element CHAIN_LEN-1)
//   SE, SI    : scan enable and serial data into element 0 (registered)
//   BUSY      : high outside IDLE
//   DONE      : one-cycle pulse with RESP_OUT/MISMATCH valid
//   RESP_OUT  : unloaded response, bit i = element i after capture
//   MISMATCH  : any masked bit differs; cleared on an accepted START
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_LEN  = 32,
  parameter int unsigned CAP_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic [CHAIN_LEN-1:0] EXP_IN,
  input  logic [CHAIN_LEN-1:0] MASK_IN,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP_OUT,
  output logic                 MISMATCH
);

  localparam int unsigned CNT_W = cnt_width(CHAIN_LEN);
  localparam int unsigned CAP_W = cnt_width(CAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CAP_W-1:0] CAP_LAST = CAP_W'(CAP_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CAP_W-1:0]     cap_q, cap_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] mask_q, mask_d;
  logic                 se_q, se_d;
  logic                 si_q, si_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CHAIN_LEN-1:0] resp_out_q, resp_out_d;
  logic                 mismatch_q, mismatch_d;

  logic                 sr_load_c;
  logic                 sr_shift_c;
  logic                 sr_ser_in_c;
  logic [CHAIN_LEN-1:0] sr_next_c;

  // Shift register controls depend on the current state only, keeping them
  // independent of the next-state logic that consumes sr_next_c.
  always_comb begin
    sr_load_c   = (state_q == IDLE) && START;
    sr_shift_c  = (state_q == LOAD) || (state_q == UNLOAD);
    sr_ser_in_c = (state_q == UNLOAD) && SO;
  end

  scan_piso_sipo #(
    .WIDTH (CHAIN_LEN)
  ) u_sr (
    .clk        (CLK),
    .rst        (RST),
    .load       (sr_load_c),
    .shift      (sr_shift_c),
    .ser_in     (sr_ser_in_c),
    .par_in     (PAT_IN),
    .par_next_c (sr_next_c)
  );

  // Next-state, counters, latching and compare.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    exp_d      = exp_q;
    mask_d     = mask_q;
    resp_out_d = resp_out_q;
    mismatch_d = mismatch_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d    = LOAD;
          cnt_d      = '0;
          cap_d      = '0;
          exp_d      = EXP_IN;
          mask_d     = MASK_IN;
          mismatch_d = 1'b0;
        end
      end
      LOAD: begin
        if (cnt_q == CNT_LAST) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAPTURE: begin
        if (cap_q == CAP_LAST) begin
          state_d = UNLOAD;
          cap_d   = '0;
        end else begin
          cap_d = cap_q + CAP_W'(1);
        end
      end
      UNLOAD: begin
        if (cnt_q == CNT_LAST) begin
          // The last SO bit enters on this edge, so sr_next_c is the full response.
          state_d    = REPORT;
          cnt_d      = '0;
          resp_out_d = sr_next_c;
          mismatch_d = |((sr_next_c ^ exp_q) & mask_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they align with it.
    se_d   = (state_d == LOAD) || (state_d == UNLOAD);
    si_d   = (state_d == LOAD) ? sr_next_c[CHAIN_LEN-1] : 1'b0;
    busy_d = (state_d != IDLE);
    done_d = (state_d == REPORT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cap_q      <= '0;
      exp_q      <= '0;
      mask_q     <= '0;
      se_q       <= 1'b0;
      si_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      resp_out_q <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      exp_q      <= exp_d;
      mask_q     <= mask_d;
      se_q       <= se_d;
      si_q       <= si_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      resp_out_q <= resp_out_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign SE       = se_q;
  assign SI       = si_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign RESP_OUT = resp_out_q;
  assign MISMATCH = mismatch_q;

endmodule
